// File: rtl/rapcla_err_meter_if.sv
// Sample/control bundle for the approximate-adder error meter.
// Handshake: a sample transfers on a rising clk edge where in_valid && in_ready; in_ready never depends on in_valid.
interface rapcla_err_meter_if #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
);
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE:1]    approx_sum;
  logic             approx_cout;
  logic [SIZE:1]    exact_sum;
  logic             exact_cout;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;
  logic [ACC_W-1:0] sum_ed;
  logic [SIZE:0]    max_ed;
  logic [1:0]       dbg_state;

  modport master (
    output start, num_samples, in_valid, approx_sum, approx_cout, exact_sum, exact_cout,
    input  in_ready, busy, done, sample_count, err_count, sum_ed, max_ed, dbg_state
  );

  modport slave (
    input  start, num_samples, in_valid, approx_sum, approx_cout, exact_sum, exact_cout,
    output in_ready, busy, done, sample_count, err_count, sum_ed, max_ed, dbg_state
  );
endinterface

// File: rtl/rapcla_err_meter.sv
// Error-distance statistics over a programmed number of approx/exact adder result pairs.
// Stage 1 registers |E-A|; stage 2 folds it into error count, saturating sum and max.
module rapcla_err_meter #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  rapcla_err_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  localparam int AW1 = ACC_W + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, sample_count_q, err_count_q;
  logic [ACC_W-1:0] sum_ed_q;
  logic [SIZE:0]    max_ed_q, ed_q;
  logic             v1_q;

  logic             in_ready;
  logic             accept;
  logic             start_ok;
  logic             last_accept;
  logic [SIZE+1:0]  e_x, a_x, diff;
  logic [SIZE:0]    ed_d;
  logic [ACC_W:0]   sum_full;

  assign in_ready    = (state_q == RUN);
  assign accept      = bus.in_valid && in_ready;
  assign start_ok    = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_accept = accept && ((sample_count_q + CNT_W'(1)) == target_q);

  // Widen by one bit so the subtraction cannot wrap; the magnitude always fits SIZE+1 bits.
  assign e_x  = {1'b0, bus.exact_cout, bus.exact_sum};
  assign a_x  = {1'b0, bus.approx_cout, bus.approx_sum};
  assign diff = (e_x >= a_x) ? (e_x - a_x) : (a_x - e_x);
  assign ed_d = diff[SIZE:0];

  assign sum_full = {1'b0, sum_ed_q} + AW1'(ed_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (bus.start) state_d = (bus.num_samples == '0) ? DONE : RUN;
      RUN:        if (last_accept) state_d = DRAIN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      target_q       <= '0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_ed_q       <= '0;
      max_ed_q       <= '0;
      ed_q           <= '0;
      v1_q           <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        target_q       <= bus.num_samples;
        sample_count_q <= '0;
        err_count_q    <= '0;
        sum_ed_q       <= '0;
        max_ed_q       <= '0;
        v1_q           <= 1'b0;
      end else begin
        v1_q <= accept;
        if (accept) begin
          ed_q           <= ed_d;
          sample_count_q <= sample_count_q + CNT_W'(1);
        end
        if (v1_q) begin
          if (ed_q != '0) err_count_q <= err_count_q + CNT_W'(1);
          sum_ed_q <= sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];
          if (ed_q > max_ed_q) max_ed_q <= ed_q;
        end
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.busy         = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done         = (state_q == DONE);
  assign bus.sample_count = sample_count_q;
  assign bus.err_count    = err_count_q;
  assign bus.sum_ed       = sum_ed_q;
  assign bus.max_ed       = max_ed_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_rapcla_err_meter.sv
// Directed bench for rapcla_err_meter: single-sample vector table plus multi-cycle sequences.
// A second instance with a 9-bit accumulator mirrors the same stimulus to exercise saturation.
module tb_rapcla_err_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rapcla_err_meter_if #(.SIZE(8), .CNT_W(16), .ACC_W(32)) b0 ();
  rapcla_err_meter_if #(.SIZE(8), .CNT_W(16), .ACC_W(9))  b1 ();

  rapcla_err_meter #(.SIZE(8), .CNT_W(16), .ACC_W(32)) u0 (.clk(clk), .rst(rst), .bus(b0));
  rapcla_err_meter #(.SIZE(8), .CNT_W(16), .ACC_W(9))  u1 (.clk(clk), .rst(rst), .bus(b1));

  assign b1.start       = b0.start;
  assign b1.num_samples = b0.num_samples;
  assign b1.in_valid    = b0.in_valid;
  assign b1.approx_sum  = b0.approx_sum;
  assign b1.approx_cout = b0.approx_cout;
  assign b1.exact_sum   = b0.exact_sum;
  assign b1.exact_cout  = b0.exact_cout;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [8:0] e;
    logic [8:0] a;
    logic [8:0] ed;
  } vec_t;
  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_start(input logic [15:0] n);
    b0.start       = 1'b1;
    b0.num_samples = n;
    tick();
    b0.start = 1'b0;
  endtask

  task automatic feed(input logic [8:0] e, input logic [8:0] a);
    {b0.exact_cout, b0.exact_sum}   = e;
    {b0.approx_cout, b0.approx_sum} = a;
    b0.in_valid = 1'b1;
  endtask

  task automatic chk_stats(input string tag, input int sc, input int ec, input int se, input int me);
    chk({tag, " sample_count"}, b0.sample_count, sc);
    chk({tag, " err_count"}, b0.err_count, ec);
    chk({tag, " sum_ed"}, b0.sum_ed, se);
    chk({tag, " max_ed"}, b0.max_ed, me);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " state"}, b0.dbg_state, 0);
    chk({tag, " in_ready"}, b0.in_ready, 0);
    chk({tag, " busy"}, b0.busy, 0);
    chk({tag, " done"}, b0.done, 0);
    chk_stats(tag, 0, 0, 0, 0);
  endtask

  initial begin
    vecs[0] = '{e: 9'h0F0, a: 9'h0F0, ed: 9'd0};
    vecs[1] = '{e: 9'h1F0, a: 9'h0F0, ed: 9'd256};
    vecs[2] = '{e: 9'h010, a: 9'h013, ed: 9'd3};
    vecs[3] = '{e: 9'h1FF, a: 9'h000, ed: 9'd511};
    vecs[4] = '{e: 9'h000, a: 9'h1FF, ed: 9'd511};
    vecs[5] = '{e: 9'h0AA, a: 9'h055, ed: 9'd85};
    vecs[6] = '{e: 9'h100, a: 9'h0FF, ed: 9'd1};

    b0.start = 1'b0; b0.num_samples = '0; b0.in_valid = 1'b0;
    b0.exact_sum = '0; b0.exact_cout = 1'b0; b0.approx_sum = '0; b0.approx_cout = 1'b0;

    // Reset and idle: valid with no start is ignored.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    feed(9'h1FF, 9'h000);
    tick(); tick();
    chk_idle("reset_idle");
    b0.in_valid = 1'b0;

    // Single-sample runs from the vector table.
    for (int i = 0; i < 7; i++) begin
      run_start(16'd1);
      chk($sformatf("vec%0d busy", i), b0.busy, 1);
      chk($sformatf("vec%0d in_ready", i), b0.in_ready, 1);
      feed(vecs[i].e, vecs[i].a);
      tick();
      b0.in_valid = 1'b0;
      chk($sformatf("vec%0d ready_drop", i), b0.in_ready, 0);
      chk($sformatf("vec%0d early_done", i), b0.done, 0);
      chk($sformatf("vec%0d sc_T1", i), b0.sample_count, 1);
      tick();
      chk($sformatf("vec%0d done", i), b0.done, 1);
      chk_stats($sformatf("vec%0d", i), 1, (vecs[i].ed != 0) ? 1 : 0, vecs[i].ed, vecs[i].ed);
    end

    // Carry error, back-to-back samples.
    run_start(16'd2);
    feed(9'h1F0, 9'h0F0);
    tick();
    chk("carry sc_mid", b0.sample_count, 1);
    chk("carry ready_mid", b0.in_ready, 1);
    feed(9'h010, 9'h013);
    tick();
    chk("carry ready_drop", b0.in_ready, 0);
    chk("carry done_T1", b0.done, 0);
    chk("carry sum_T1", b0.sum_ed, 256);
    tick();
    chk("carry done_T2", b0.done, 1);
    chk_stats("carry", 2, 2, 259, 256);
    tick(); tick();
    b0.in_valid = 1'b0;
    chk("carry done_hold", b0.done, 1);
    chk_stats("carry_hold", 2, 2, 259, 256);

    // Gapped valid with a start pulse that must be ignored; ED of sample i is i.
    run_start(16'd4);
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int i = 0; i < 6; i++) begin
        feed(9'(i), 9'h000);
        b0.in_valid = pat[i];
        if (i == 2) begin
          b0.start       = 1'b1;
          b0.num_samples = 16'd9;
        end
        tick();
        b0.start = 1'b0;
        if (i == 2) chk("gap sc_after_start", b0.sample_count, 2);
      end
    end
    b0.in_valid = 1'b0;
    chk("gap ready_drop", b0.in_ready, 0);
    chk("gap busy", b0.busy, 1);
    chk("gap sc", b0.sample_count, 4);
    tick();
    chk("gap done", b0.done, 1);
    chk_stats("gap", 4, 3, 10, 5);

    // Zero samples from DONE, then restart with three.
    run_start(16'd0);
    chk("zero done", b0.done, 1);
    chk("zero busy", b0.busy, 0);
    chk("zero in_ready", b0.in_ready, 0);
    chk_stats("zero", 0, 0, 0, 0);
    run_start(16'd3);
    chk("restart busy", b0.busy, 1);
    chk("restart done", b0.done, 0);
    chk_stats("restart_clr", 0, 0, 0, 0);
    feed(9'h020, 9'h010); tick();
    feed(9'h010, 9'h020); tick();
    feed(9'h033, 9'h033); tick();
    b0.in_valid = 1'b0;
    chk("restart ready_drop", b0.in_ready, 0);
    tick();
    chk("restart done_T2", b0.done, 1);
    chk_stats("restart", 3, 2, 32, 16);

    // Reset mid-run after two of five accepts.
    run_start(16'd5);
    feed(9'h1FF, 9'h000); tick();
    feed(9'h1FF, 9'h000); tick();
    b0.in_valid = 1'b0;
    chk("abort sc_before", b0.sample_count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("abort");

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    b0.start = 1'b1;
    b0.num_samples = 16'd2;
    tick();
    rst = 1'b0;
    b0.start = 1'b0;
    chk("rst_start state", b0.dbg_state, 0);
    chk("rst_start busy", b0.busy, 0);

    // Saturation: three ED=511 samples into a 9-bit accumulator.
    run_start(16'd3);
    feed(9'h000, 9'h1FF); tick();
    feed(9'h000, 9'h1FF); tick();
    feed(9'h000, 9'h1FF); tick();
    b0.in_valid = 1'b0;
    tick();
    chk("sat done", b1.done, 1);
    chk("sat sum_ed", b1.sum_ed, 511);
    chk("sat max_ed", b1.max_ed, 511);
    chk("sat err_count", b1.err_count, 3);
    chk("wide sum_ed", b0.sum_ed, 1533);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rapcla_err_meter.md
# rapcla_err_meter

Downstream error-characterisation stage for the reconfigurable approximate carry look-ahead adder. Consumes, per sample, the approximate adder result and the exact adder result for the same operands, computes the error distance, and accumulates error statistics over a programmed number of samples. Results feed the accuracy sweeps that choose `groupsize`/`window` settings.

## Interface
Parameters:
- `SIZE`, 8: adder width. Each result is `{COUT,SUM}`, `SIZE+1` bits unsigned.
- `CNT_W`, 16: width of the sample and error counters.
- `ACC_W`, 32: width of the error-distance accumulator.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- `num_samples`  in  CNT_W  samples per run, latched on an accepted `start`.
- `in_valid`  in  1  sample present on the `approx_*`/`exact_*` inputs.
- `in_ready`  out  1  block accepts a sample this cycle.
- `approx_sum`  in  [SIZE:1]  approximate adder SUM.
- `approx_cout`  in  1  approximate adder COUT.
- `exact_sum`  in  [SIZE:1]  exact adder SUM.
- `exact_cout`  in  1  exact adder COUT.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE.
- `sample_count`  out  CNT_W  samples accepted in the current or last run.
- `err_count`  out  CNT_W  samples with a nonzero error distance (ED).
- `sum_ed`  out  ACC_W  sum of ED, saturating.
- `max_ed`  out  SIZE+1  maximum ED.

## Operation
- Values: `E = {exact_cout,exact_sum}` and `A = {approx_cout,approx_sum}`, both unsigned and `SIZE+1` bits. `ED = |E − A|`, computed at `SIZE+2` bits with the result truncated to `SIZE+1`, which is lossless.
- Pipeline stage 1: on each accept (`in_valid && in_ready`), register `ED` and raise `v1`.
- Pipeline stage 2: when `v1` is set, update the statistics:
  - `err_count += (ED != 0)`
  - `sum_ed += ED`, saturating at all-ones
  - `max_ed = max(max_ed, ED)`
- `sample_count` increments in the accept cycle. The stage-2 statistics increment in the following cycle.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE, `start`: latch `num_samples` into `target`, clear all statistics and `sample_count`. Go to RUN, or to DONE if `num_samples == 0`.
  - RUN: `in_ready = 1`. When an accept makes `sample_count == target`, go to DRAIN.
  - DRAIN: `in_ready = 0`. After one cycle, once stage 2 has absorbed the last sample, go to DONE.
  - DONE: `done = 1` and outputs hold. `start` behaves as it does in IDLE: it clears the statistics and begins a new run.
- `start` in RUN or DRAIN is ignored.
- `in_valid` is ignored whenever `in_ready = 0`. The `approx_*` and `exact_*` inputs are don't-care when `in_valid = 0`.
- `in_ready` does not depend combinationally on `in_valid`.
- `rst` in any state aborts the run immediately, with no completion.

## Timing
- Reset values: state IDLE, and `in_ready`, `busy`, `done`, `sample_count`, `err_count`, `sum_ed`, `max_ed`, `v1`, `target` all 0.
- `start` accepted at cycle S:
  - `busy` and `in_ready` are 1 from S+1.
  - If `num_samples == 0`, `done` is 1 from S+1 and all statistics are 0.
- Last sample accepted at cycle T:
  - `in_ready` is 0 from T+1.
  - Final statistics are valid and `done` is 1 from T+2.
- Throughput: one sample per cycle with no bubbles while `in_valid` is held high.
- Statistics may be observed mid-run. Each value lags the accepts by one cycle.
- `start` and `rst` in the same cycle: `rst` wins.

## Test plan
- **Reset and idle:** reset for 2 cycles, then `in_valid = 1` with no `start` → `in_ready = 0`, all outputs 0, `sample_count` stays 0.
- **Single-sample exact match:** `SIZE = 8`, `num_samples = 1`, E = A = 9'h0F0 → `done` at T+2, `sample_count = 1`, `err_count = 0`, `sum_ed = 0`, `max_ed = 0`.
- **Carry error:** E = 9'h1F0, A = 9'h0F0 (ED = 256); then E = 9'h010, A = 9'h013 (ED = 3); `num_samples = 2`, back-to-back → `err_count = 2`, `sum_ed = 259`, `max_ed = 256`, `done` exactly 2 cycles after the second accept.
- **Gapped valid plus ignored start:** `num_samples = 4`, `in_valid` toggling 1,0,1,1,0,1 with `start` pulsed mid-run → exactly 4 accepts, `in_ready` drops the cycle after the 4th, and `start` has no effect.
- **Zero samples and restart:** `num_samples = 0` → `done` at S+1 with all statistics 0. Then from DONE, `start` with `num_samples = 3` → statistics cleared at S+1 and a new run completes correctly.
- **Reset mid-run and saturation:**
  - `rst` after 2 of 5 accepts → next cycle is IDLE with all outputs 0.
  - With `ACC_W = 9`, feed three ED = 511 samples → `sum_ed = 511`, saturated.
